// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the memory port of mem_port_arbiter.
//   slave  : the arbiter's view. It takes the requests and m_rdata, and it drives the
//            acks, stalls, rdata and the m_* strobes.
//   master : the environment's view. This is the fetch/memory stages plus the memory.
interface mem_port_arbiter_if;
  // Fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  // Data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  // Memory port
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
    output m_en, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
    input  m_en, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the fetch port and the data port.
// Each access runs through the sequence IDLE -> ISSUE -> (WAIT) -> RESP.
// Data has priority. The fetch port wins once STARVE_MAX data grants have been made in a
// row while it was waiting.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   bus        : mem_port_arbiter_if.slave. It carries the fetch port (if_*), the data
//                port (d_*) and the memory port (m_*).
module mem_port_arbiter #(
  parameter int unsigned LAT        = 2,  // issue cycle to valid m_rdata, >= 1
  parameter int unsigned STARVE_MAX = 4   // data grants in a row while fetch waits
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned WaitW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic               port_q;     // 1 = data port owns the transaction
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [WaitW-1:0]   wait_q;
  logic [StarveW-1:0] starve_q;
  logic               kill_q;     // flushed fetch: the access finishes, the ack does not
  logic [31:0]        if_rdata_q;
  logic [31:0]        d_rdata_q;

  logic grant_valid;
  logic grant_data;
  logic starve_hit;

  assign starve_hit  = (starve_q == StarveW'(STARVE_MAX));
  assign grant_valid = (state_q == StIdle) && (bus.if_req || bus.d_req);
  assign grant_data  = bus.d_req && !(bus.if_req && starve_hit);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.if_req || bus.d_req) state_d = StIssue;
      StIssue: state_d = we_q ? StResp : StWait;
      StWait:  if (wait_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.m_en     = (state_q == StIssue);
    bus.m_we     = (state_q == StIssue) && we_q;
    bus.m_wstrb  = ((state_q == StIssue) && we_q) ? wstrb_q : 4'h0;
    bus.m_addr   = addr_q;
    bus.m_wdata  = wdata_q;
    // A flush in the RESP cycle itself also suppresses the ack.
    bus.if_ack   = (state_q == StResp) && !port_q && !kill_q && !bus.if_flush;
    bus.d_ack    = (state_q == StResp) && port_q;
    bus.if_rdata = if_rdata_q;
    bus.d_rdata  = d_rdata_q;
    bus.if_stall = bus.if_req && !bus.if_ack;
    bus.d_stall  = bus.d_req && !bus.d_ack;
  end

  // Grant latch, starvation counter, wait counter, kill flag, response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wait_q     <= '0;
      starve_q   <= '0;
      kill_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_valid) begin
        port_q <= grant_data;
        if (grant_data) begin
          we_q    <= bus.d_we;
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          wstrb_q <= bus.d_wstrb;
          if (!bus.if_req) begin
            starve_q <= '0;
          end else if (!starve_hit) begin
            starve_q <= starve_q + 1'b1;
          end
        end else begin
          we_q     <= 1'b0;
          addr_q   <= bus.if_addr;
          starve_q <= '0;
        end
      end

      if (state_q == StIssue && !we_q) begin
        wait_q <= WaitW'(LAT - 1);
      end else if (state_q == StWait && wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end

      if (state_q == StWait && wait_q == '0) begin
        if (port_q) d_rdata_q  <= bus.m_rdata;
        else        if_rdata_q <= bus.m_rdata;
      end

      if (state_q == StIdle || state_q == StResp) begin
        kill_q <= 1'b0;
      end else if (!port_q && bus.if_flush) begin
        kill_q <= 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous memory between the fetch stage (instruction port) and the memory stage (data port) of the RV32I pipeline. It arbitrates, sequences each access through issue, wait and response, and returns per-port acknowledge and stall signals. The fetch stage uses `if_stall` to hold its PC, and the memory stage uses `d_stall` to freeze the pipeline. Data accesses have priority, and a starvation limit guarantees forward progress for fetch.

## Interface
- `LAT`, default 2: memory read latency in cycles from the issue cycle to valid `m_rdata`. Must be ≥1.
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while `if_req` is pending.
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until the `if_ack` cycle.
- `if_addr`  in  32  fetch byte address.
- `if_flush`  in  1  cancels the pending or in-flight fetch response.
- `if_rdata`  out  32  fetched word; valid when `if_ack` = 1.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_stall`  out  1  equals `if_req & ~if_ack`.
- `d_req`  in  1  data request; held until the `d_ack` cycle.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_wstrb`  in  4  byte enables for writes.
- `d_rdata`  out  32  read data; valid when `d_ack` = 1.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  equals `d_req & ~d_ack`.
- `m_en`  out  1  memory access strobe; high for exactly one cycle per access.
- `m_we`  out  1  write enable, qualified by `m_en`.
- `m_addr`  out  32  address, passed unmodified (bits [1:0] included).
- `m_wdata`  out  32  write data.
- `m_wstrb`  out  4  byte enables. Forced to 0 on reads.
- `m_rdata`  in  32  read data, valid exactly `LAT` cycles after the `m_en` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** Arbitration happens only in this state. If either request is high, latch the winner (port, addr, we, wdata, wstrb) and go to ISSUE. Otherwise stay in IDLE.
- **Arbitration rule.**
  - Data wins when both requests are high.
  - Exception: fetch wins if `starve_cnt == STARVE_MAX`.
  - `starve_cnt` increments, saturating at `STARVE_MAX`, on each data grant made while `if_req` = 1.
  - `starve_cnt` clears on any fetch grant, and on a data grant made while `if_req` = 0.
- **ISSUE.** Drive `m_en` = 1 and the latched `m_*` values for one cycle.
  - Write: go to RESP.
  - Read: go to WAIT and load the wait counter with `LAT`−1.
- **WAIT.** Decrement the counter each cycle. When it reaches 0, sample `m_rdata` into the response register and go to RESP.
  - For `LAT` = 1, WAIT lasts one cycle and sampling happens in that cycle.
- **RESP.** Pulse the granted port's ack for one cycle with its rdata register driven (the last read value is held on writes), then return to IDLE.
- **Outputs in non-ISSUE states.** `m_en`, `m_we` and `m_wstrb` are 0, and `m_addr`/`m_wdata` hold their last values.
- **Fetch flush.** A flush kills the response, not the memory access.
  - If `if_flush` = 1 in any cycle while a fetch is granted (ISSUE, WAIT or RESP), set a kill flag. The memory access still completes, but `if_ack` is suppressed in RESP. The flag clears on return to IDLE.
  - `if_flush` has no effect on a data transaction or in IDLE.
  - After a flush the fetch stage presents the new address with `if_req`. That request is arbitrated as a new request on the next IDLE.
- **Request rules for both ports.**
  - A requester holds its request and request fields stable through its ack cycle.
  - It may deassert, or present a new request, in the cycle after ack.
  - Changing fields mid-transaction has no effect, because the values were latched at grant.
- **Reset.**
  - State returns to IDLE, and `starve_cnt`, the wait counter and the kill flag clear.
  - `if_ack`, `d_ack`, `if_rdata`, `d_rdata`, `m_en`, `m_we`, `m_addr`, `m_wdata` and `m_wstrb` all go to 0.
  - Any in-flight access is abandoned, with no ack after reset. `m_en` drops immediately because reset is asynchronous.
  - The stalls follow their combinational definition and equal the raw requests.

## Timing
- Request first seen in IDLE in cycle T:
  - `m_en` is high in T+1.
  - Read: `m_rdata` is sampled in T+1+`LAT` and ack is high in T+2+`LAT`.
  - Write: ack is high in T+2.
- Back-to-back: the next grant can occur in T+3+`LAT` (read) or T+3 (write), the IDLE cycle after RESP.
- Stall visibility: `if_stall`/`d_stall` are high from the first request cycle up to, but not including, the ack cycle.
- The losing port's stall stays high across the whole winning transaction.

## Test plan
- **Single fetch.** `LAT`=2, `if_req` rises in cycle 0 with `if_addr`=0x40, and memory returns 0xDEADBEEF.
  - `m_en` is high in cycle 1 with `m_addr`=0x40.
  - `if_ack` is high in cycle 4 with `if_rdata`=0xDEADBEEF.
  - `if_stall` is high in cycles 0–3.
- **Write timing.** `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0x12345678, `d_wstrb`=0x3 in cycle 0.
  - `m_en`=`m_we`=1, `m_wstrb`=0x3 in cycle 1.
  - `d_ack` is high in cycle 2.
- **Simultaneous requests.** `if_req` and a `d_req` read both rise in cycle 0.
  - The data access issues in cycle 1 and `d_ack` is high in cycle 4.
  - The fetch issues in cycle 6 and `if_ack` is high in cycle 9.
- **Starvation.** `STARVE_MAX`=4, `if_req` held high, and `d_req` re-asserted after every ack.
  - Four data grants occur, then a fetch grant, then data resumes.
- **Flush.** Assert `if_flush` in the WAIT cycle of a fetch.
  - `m_en` pulses once and no `if_ack` occurs.
  - The new `if_req` for 0x80 is granted on the following IDLE and acked normally.
- **Reset mid-read.** Assert `reset` during WAIT.
  - All outputs go to 0 immediately and no ack follows.
  - After release, a pending `d_req` is issued in the cycle after the first post-reset IDLE cycle.
